// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one multi-cycle FP adder (Go/Done) among NREQ
// requesters; returns each result over a one-hot valid/ready response channel.
module fp_add_scheduler #(
  parameter int NREQ         = 4,
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int WIDTH        = 1 + EXPBITS + MANTISSABITS,
  parameter int TIMEOUT      = 64
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            ReqValid,
  input  logic [NREQ*WIDTH-1:0]      ReqA,
  input  logic [NREQ*WIDTH-1:0]      ReqB,
  output logic [NREQ-1:0]            ReqReady,
  output logic                       AddGo,
  output logic [WIDTH-1:0]           AddA,
  output logic [WIDTH-1:0]           AddB,
  input  logic                       AddDone,
  input  logic [WIDTH-1:0]           AddResult,
  output logic [NREQ-1:0]            RspValid,
  output logic [WIDTH-1:0]           RspData,
  input  logic [NREQ-1:0]            RspReady,
  output logic                       Busy,
  output logic [$clog2(NREQ)-1:0]    Grant,
  output logic                       TimeoutErr
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              found;
  logic [GW-1:0]     win;
  logic [WIDTH-1:0]  a_sel, b_sel;

  // Round-robin: first search above the last grant, then wrap from zero.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++)
      if (!found && ReqValid[i] && (GW'(i) > last_grant_q)) begin
        found = 1'b1;
        win   = GW'(i);
      end
    for (int i = 0; i < NREQ; i++)
      if (!found && ReqValid[i]) begin
        found = 1'b1;
        win   = GW'(i);
      end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (GW'(i) == win) begin
        a_sel = ReqA[i*WIDTH +: WIDTH];
        b_sel = ReqB[i*WIDTH +: WIDTH];
      end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    add_a_d       = add_a_q;
    add_b_d       = add_b_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = rsp_valid_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    ReqReady      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ReqReady = NREQ'(1) << win;
          add_a_d  = a_sel;
          add_b_d  = b_sel;
          grant_d  = win;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over a watchdog expiring in the same cycle.
        if (AddDone) begin
          rsp_data_d  = AddResult;
          rsp_valid_d = NREQ'(1) << grant_q;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          timeout_err_d = 1'b1;
          last_grant_d  = grant_q;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (RspReady[grant_q]) begin
          rsp_valid_d  = '0;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GW'(NREQ-1);
      grant_q       <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      add_a_q       <= add_a_d;
      add_b_q       <= add_b_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign AddGo      = (state_q == S_ISSUE);
  assign AddA       = add_a_q;
  assign AddB       = add_b_q;
  assign RspValid   = rsp_valid_q;
  assign RspData    = rsp_data_q;
  assign Busy       = (state_q != S_IDLE);
  assign Grant      = grant_q;
  assign TimeoutErr = timeout_err_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler: randomized requesters, an adder stub
// and a timestamp-based reference model of grants, responses and timeouts.
module tb_fp_add_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TMO  = 8;

  logic                 clk = 1'b0;
  logic                 Reset;
  logic [NREQ-1:0]      ReqValid;
  logic [NREQ*W-1:0]    ReqA, ReqB;
  logic [NREQ-1:0]      ReqReady;
  logic                 AddGo;
  logic [W-1:0]         AddA, AddB;
  logic                 AddDone;
  logic [W-1:0]         AddResult;
  logic [NREQ-1:0]      RspValid;
  logic [W-1:0]         RspData;
  logic [NREQ-1:0]      RspReady;
  logic                 Busy;
  logic [1:0]           Grant;
  logic                 TimeoutErr;

  fp_add_scheduler #(.NREQ(NREQ), .EXPBITS(8), .MANTISSABITS(23), .TIMEOUT(TMO)) dut (
    .Clock(clk), .Reset(Reset), .ReqValid(ReqValid), .ReqA(ReqA), .ReqB(ReqB),
    .ReqReady(ReqReady), .AddGo(AddGo), .AddA(AddA), .AddB(AddB), .AddDone(AddDone),
    .AddResult(AddResult), .RspValid(RspValid), .RspData(RspData), .RspReady(RspReady),
    .Busy(Busy), .Grant(Grant), .TimeoutErr(TimeoutErr));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Single-precision add via double arithmetic (normal operands only).
  function automatic real s2r(logic [31:0] x);
    return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0});
  endfunction
  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    logic [63:0] d;
    d = $realtobits(s2r(a) + s2r(b));
    if (d[62:0] == 63'd0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // ---------------- adder stub ----------------
  int cfg_dly = 5;
  int stub_dly = 0;
  int remain = 0;
  bit inflight = 0;
  initial begin
    AddDone = 1'b0; AddResult = '0;
    forever begin
      @(posedge clk); #1;
      AddDone = 1'b0;
      AddResult = $urandom;
      if (AddGo) begin
        inflight = 1;
        if (cfg_dly != 0) remain = cfg_dly;
        else remain = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(1, TMO);
        stub_dly = remain;
        if ($urandom_range(0, 3) == 0) AddDone = 1'b1;   // spurious, in ISSUE
      end else if (inflight) begin
        remain--;
        if (remain == 0) begin
          AddDone = 1'b1;
          AddResult = fadd(AddA, AddB);
          inflight = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        AddDone = 1'b1;                                  // spurious, outside WAIT
      end
    end
  end

  // ---------------- reference model / scoreboard monitor ----------------
  typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic [31:0] res; } ent_t;
  ent_t sb[$];
  int grant_log[$];
  logic [W-1:0] pa [NREQ];
  logic [W-1:0] pb [NREQ];
  logic [NREQ-1:0] pend = '0, acc_seen = '0;
  bit mon_on = 0, m_busy = 0, m_rsp_on = 0, m_terr = 0;
  int m_last = NREQ-1, m_grant = 0, m_go_cyc = -1, m_done_cyc = -1, m_to_cyc = -1;
  logic [31:0] m_a = '0, m_b = '0, m_rsp_data = '0, last_rsp = '0;
  logic [NREQ-1:0] exp_rr, exp_rv;
  int w;

  always @(negedge clk) begin
    exp_rr = '0;
    w = -1;
    if (!m_busy && ReqValid != '0) begin
      w = rr_pick(m_last, ReqValid);
      exp_rr[w] = 1'b1;
    end
    if (mon_on) begin
      exp_rv = '0;
      if (m_rsp_on) exp_rv[sb[0].idx] = 1'b1;
      chk("req_ready", 32'(ReqReady), 32'(exp_rr));
      chk("add_go", 32'(AddGo), 32'(cyc == m_go_cyc));
      chk("busy", 32'(Busy), 32'(m_busy));
      chk("grant", 32'(Grant), 32'(m_grant));
      chk("timeout_err", 32'(TimeoutErr), 32'(m_terr));
      chk("add_a", AddA, m_a);
      chk("add_b", AddB, m_b);
      chk("rsp_valid", 32'(RspValid), 32'(exp_rv));
      chk("rsp_data", RspData, m_rsp_data);
    end
    acc_seen = Reset ? '0 : (ReqReady & ReqValid);
    if (Reset) begin
      mon_on = 1; m_busy = 0; m_rsp_on = 0; m_terr = 0;
      m_last = NREQ-1; m_grant = 0; m_a = '0; m_b = '0; m_rsp_data = '0;
      m_go_cyc = -1; m_done_cyc = -1; m_to_cyc = -1;
      sb.delete();
    end else begin
      if (m_rsp_on && RspReady[sb[0].idx]) begin
        last_rsp = sb[0].res;
        m_last = sb[0].idx; m_busy = 0; m_rsp_on = 0;
        void'(sb.pop_front());
      end
      if (cyc == m_go_cyc) begin
        if (stub_dly <= TMO) m_done_cyc = cyc + stub_dly;
        else m_to_cyc = cyc + TMO;
      end
      if (cyc == m_done_cyc) begin
        m_rsp_on = 1; m_rsp_data = sb[0].res; m_done_cyc = -1;
      end
      if (cyc == m_to_cyc) begin
        m_terr = 1; m_busy = 0; m_last = sb[0].idx; m_to_cyc = -1;
        void'(sb.pop_front());
      end
      if (w >= 0) begin
        sb.push_back('{idx: w, a: pa[w], b: pb[w], res: fadd(pa[w], pb[w])});
        m_busy = 1; m_grant = w; m_a = pa[w]; m_b = pb[w]; m_go_cyc = cyc + 1;
        grant_log.push_back(w);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit auto_rearm = 0, rand_req = 0, rand_rsp = 0;

  task automatic new_op(int i);
    pend[i] = 1'b1; pa[i] = rnd_fp(); pb[i] = rnd_fp();
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_seen[i]) pend[i] = 1'b0;
      if (!pend[i] && (auto_rearm || (rand_req && $urandom_range(0, 3) == 0))) new_op(i);
    end
    acc_seen = '0;
    if (rand_rsp) RspReady = NREQ'($urandom);
    ReqValid = pend;
    for (int i = 0; i < NREQ; i++) begin
      ReqA[i*W +: W] = pa[i];
      ReqB[i*W +: W] = pb[i];
    end
  endtask

  task automatic wait_idle(string nm, int max);
    int n = 0;
    while ((pend != '0 || m_busy || sb.size() != 0) && n < max) begin tick(); n++; end
    if (n >= max) begin
      n_tests++; n_fail++;
      $display("FAIL %s: not idle after %0d cycles", nm, max);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; tick(); tick(); Reset = 1'b0; tick();
    grant_log.delete();
  endtask

  initial begin
    Reset = 1'b1; ReqValid = '0; ReqA = '0; ReqB = '0; RspReady = '1;
    for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; end
    do_reset();
    repeat (3) tick();

    // Single request 1.0 + 2.0
    cfg_dly = 5;
    pend[0] = 1'b1; pa[0] = 32'h3F800000; pb[0] = 32'h40000000;
    wait_idle("single", 40);
    tick();
    chk("single_rsp_data", last_rsp, 32'h40400000);
    chk("single_busy_after", 32'(Busy), 32'd0);

    // Round-robin with all requesters continuously active
    do_reset();
    cfg_dly = 0; auto_rearm = 1;
    for (int n = 0; n < 300 && grant_log.size() < 8; n++) tick();
    auto_rearm = 0;
    wait_idle("rr_drain", 400);
    chk("rr_count", 32'(grant_log.size() >= 5), 32'd1);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_order", grant_log[k], k % NREQ);

    // Backpressure on the response channel
    do_reset();
    cfg_dly = 3; RspReady = '0;
    new_op(2);
    for (int n = 0; n < 30 && !m_rsp_on; n++) tick();
    new_op(1);
    repeat (10) tick();
    chk("bp_rsp_valid", 32'(RspValid), 32'b0100);
    chk("bp_no_new_grant", grant_log.size(), 1);
    RspReady = '1;
    wait_idle("bp_drain", 60);
    chk("bp_next_grant", grant_log[grant_log.size()-1], 1);

    // Done on the last WAIT cycle, then a real timeout
    do_reset();
    cfg_dly = TMO;
    new_op(3);
    wait_idle("boundary", 40);
    chk("boundary_terr", 32'(TimeoutErr), 32'd0);
    cfg_dly = 1000;
    new_op(1);
    wait_idle("timeout", 40);
    tick();
    chk("timeout_terr", 32'(TimeoutErr), 32'd1);
    cfg_dly = 2;
    new_op(1); new_op(2);
    wait_idle("after_timeout", 60);
    chk("after_to_grant", grant_log[2], 2);

    // Wrap: LastGrant = NREQ-1 with requesters 0 and 3 pending
    do_reset();
    new_op(0); new_op(3);
    wait_idle("wrap", 60);
    chk("wrap_first", grant_log[0], 0);
    chk("wrap_second", grant_log[1], 3);

    // Reset in the middle of WAIT, with the adder finishing afterwards
    cfg_dly = 6;
    new_op(2);
    repeat (4) tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    repeat (8) tick();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_rsp_valid", 32'(RspValid), 32'd0);
    chk("rst_terr", 32'(TimeoutErr), 32'd0);
    chk("rst_add_a", AddA, 32'd0);
    grant_log.delete();
    new_op(1); new_op(2);
    wait_idle("post_reset", 60);
    chk("post_reset_grant", grant_log[0], 1);

    // Random traffic with backpressure, timeouts and spurious Done pulses
    cfg_dly = 0; rand_req = 1; rand_rsp = 1;
    repeat (600) tick();
    rand_req = 0; rand_rsp = 0; RspReady = '1;
    wait_idle("random_drain", 2000);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
